lifo_stack_ctrl: RTL and testbench

//  Consumer side of the up/down occupancy counter: a LIFO stack of DEPTH words

---
 rtl/lifo_stack_if.sv | 33 +++
 rtl/lifo_stack_ctrl.sv | 131 +++++++++++++
 tb/tb_lifo_stack_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lifo_stack_if.sv
// Handshake and status bundle for the LIFO stack controller.
// The master side (datapath controller or bench) drives requests; the slave
// side (the stack) returns readiness, popped data, occupancy and error flags.
interface lifo_stack_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic             push_valid;
    logic [WIDTH-1:0] push_data;
    logic             push_ready;
    logic             pop_valid;
    logic             pop_ready;
    logic [WIDTH-1:0] pop_data;
    logic             pop_dvalid;
    logic [ADDR:0]    count;
    logic             full;
    logic             empty;
    logic             ovf_err;
    logic             unf_err;
    logic             clr_err;

    modport master (
        output push_valid, push_data, pop_valid, clr_err,
        input  push_ready, pop_ready, pop_data, pop_dvalid,
        input  count, full, empty, ovf_err, unf_err
    );

    modport slave (
        input  push_valid, push_data, pop_valid, clr_err,
        output push_ready, pop_ready, pop_data, pop_dvalid,
        output count, full, empty, ovf_err, unf_err
    );
endinterface

// File: rtl/lifo_stack_ctrl.sv
// LIFO stack of 2**ADDR words with valid/ready push and pop, a registered pop
// data port, occupancy count, full/empty flags decoded from a three-state FSM,
// and sticky overflow/underflow error flags.
// A simultaneous push and pop on a non-empty stack replaces the top word.
module lifo_stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic        clk,
    input  logic        rst,
    lifo_stack_if.slave s_if
);
    localparam int            DEPTH      = 2 ** ADDR;
    localparam logic [ADDR:0] C_ONE      = (ADDR + 1)'(1);
    localparam logic [ADDR:0] C_DEPTH_M1 = (ADDR + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PART  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ADDR:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_dvalid;
    logic             r_ovf_err;
    logic             r_unf_err;

    logic             w_full;
    logic             w_empty;
    logic             w_push_ready;
    logic             w_pop_ready;
    logic             w_acc_push;
    logic             w_acc_pop;
    logic [ADDR-1:0]  w_top_idx;
    logic [ADDR-1:0]  w_wr_idx;

    // Flags come straight from the registered state, so they are glitch-free.
    assign w_full       = (r_state == ST_FULL);
    assign w_empty      = (r_state == ST_EMPTY);
    assign w_pop_ready  = !w_empty;
    // A push into a full stack is still taken when a pop frees the top slot.
    assign w_push_ready = !w_full || s_if.pop_valid;
    assign w_acc_push   = s_if.push_valid && w_push_ready;
    assign w_acc_pop    = s_if.pop_valid && w_pop_ready;

    // Top-of-stack slot; only meaningful when the stack is not empty.
    assign w_top_idx = ADDR'(r_count - C_ONE);
    // Push-and-pop overwrites the top; push alone writes the next free slot.
    assign w_wr_idx  = w_acc_pop ? w_top_idx : r_count[ADDR-1:0];

    // Next-state decode: only single-sided transfers change occupancy class.
    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        if (w_acc_push && !w_acc_pop) begin
            case (r_state)
                ST_EMPTY: w_state_nxt = (DEPTH == 1) ? ST_FULL : ST_PART;
                ST_PART:  if (r_count == C_DEPTH_M1) w_state_nxt = ST_FULL;
                default:  w_state_nxt = r_state;
            endcase
        end else if (w_acc_pop && !w_acc_push) begin
            case (r_state)
                ST_PART:  if (r_count == C_ONE) w_state_nxt = ST_EMPTY;
                ST_FULL:  w_state_nxt = (DEPTH == 1) ? ST_EMPTY : ST_PART;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // State register and stack pointer.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= ST_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc_push && !w_acc_pop) begin
                r_count <= r_count + C_ONE;
            end else if (w_acc_pop && !w_acc_push) begin
                r_count <= r_count - C_ONE;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        // NOTE: memory has no reset so it maps onto plain RAM; only the write is gated by rst.
        if (!rst && w_acc_push) begin
            r_mem[w_wr_idx] <= s_if.push_data;
        end
    end

    // Registered pop port: reads the old top before a same-cycle overwrite lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pop_data   <= '0;
            r_pop_dvalid <= 1'b0;
        end else begin
            r_pop_dvalid <= w_acc_pop;
            if (w_acc_pop) begin
                r_pop_data <= r_mem[w_top_idx];
            end
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (rst || s_if.clr_err) begin
            r_ovf_err <= 1'b0;
            r_unf_err <= 1'b0;
        end else begin
            if (s_if.push_valid && !w_push_ready) r_ovf_err <= 1'b1;
            if (s_if.pop_valid && w_empty)        r_unf_err <= 1'b1;
        end
    end

    assign s_if.push_ready = w_push_ready;
    assign s_if.pop_ready  = w_pop_ready;
    assign s_if.pop_data   = r_pop_data;
    assign s_if.pop_dvalid = r_pop_dvalid;
    assign s_if.count      = r_count;
    assign s_if.full       = w_full;
    assign s_if.empty      = w_empty;
    assign s_if.ovf_err    = r_ovf_err;
    assign s_if.unf_err    = r_unf_err;
endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Bench for lifo_stack_ctrl (WIDTH=8, ADDR=2, DEPTH=4). A queue-based model of
// the stack tracks contents, pop port and error flags; directed scenarios are
// followed by a randomized run compared cycle by cycle against the model.
module tb_lifo_stack_ctrl;
    localparam int WIDTH = 8;
    localparam int ADDR  = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lifo_stack_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    lifo_stack_ctrl #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_pop_data = '0;
    logic             m_dvalid   = 1'b0;
    logic             m_ovf      = 1'b0;
    logic             m_unf      = 1'b0;
    logic             exp_push_ready, exp_pop_ready;
    logic             obs_push_ready, obs_pop_ready;

    // One clock: apply inputs, capture the readies before the edge, advance
    // the model, then return #1 after the edge with registered outputs settled.
    task automatic drive_cycle(input logic pv, input logic [WIDTH-1:0] pd,
                               input logic popv, input logic clr, input logic rs);
        logic ap, ao, was_empty;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_valid  = popv;
        bus.clr_err    = clr;
        rst            = rs;
        #1;
        was_empty      = (m_q.size() == 0);
        exp_pop_ready  = !was_empty;
        exp_push_ready = (m_q.size() != DEPTH) || popv;
        obs_push_ready = bus.push_ready;
        obs_pop_ready  = bus.pop_ready;
        if (rs) begin
            m_q.delete();
            m_pop_data = '0;
            m_dvalid   = 1'b0;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
        end else begin
            ap = pv && exp_push_ready;
            ao = popv && exp_pop_ready;
            m_dvalid = ao;
            if (ao) m_pop_data = m_q.pop_back();
            if (ap) m_q.push_back(pd);
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (pv && !exp_push_ready) m_ovf = 1'b1;
                if (popv && was_empty)     m_unf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.count !== 3'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1)   begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        checks++; if (bus.full !== 1'b0)    begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
        checks++; if (bus.pop_dvalid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", bus.pop_dvalid); end
        checks++; if (bus.pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data got %h exp 00", bus.pop_data); end
        checks++; if ({bus.ovf_err, bus.unf_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {bus.ovf_err, bus.unf_err}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 8'((i + 1) * 8'h11), 1'b0, 1'b0, 1'b0);
            checks++; if (bus.count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i + 1); end
        end
        bus.push_valid = 1'b0;
        #1;
        checks++; if (bus.full !== 1'b1)       begin errors++; $display("FAIL fill_full got %b exp 1", bus.full); end
        checks++; if (bus.push_ready !== 1'b0) begin errors++; $display("FAIL fill_push_ready got %b exp 0", bus.push_ready); end
    endtask

    task automatic test_drain();
        logic [WIDTH-1:0] exp_d;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = 8'(8'h44 - i * 8'h11);
            drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checks++; if (bus.pop_dvalid !== 1'b1) begin errors++; $display("FAIL drain_dvalid[%0d] got %b exp 1", i, bus.pop_dvalid); end
            checks++; if (bus.pop_data !== exp_d)  begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, bus.pop_data, exp_d); end
            checks++; if (bus.count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, bus.count, 3 - i); end
        end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.pop_dvalid !== 1'b0) begin errors++; $display("FAIL drain_dvalid_idle got %b exp 0", bus.pop_dvalid); end
        checks++; if (bus.empty !== 1'b1)      begin errors++; $display("FAIL drain_empty got %b exp 1", bus.empty); end
        checks++; if (bus.pop_data !== 8'h11)  begin errors++; $display("FAIL drain_hold got %h exp 11", bus.pop_data); end
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (obs_pop_ready !== 1'b0)  begin errors++; $display("FAIL unf_pop_ready got %b exp 0", obs_pop_ready); end
        checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL unf_count got %0d exp 0", bus.count); end
        checks++; if (bus.unf_err !== 1'b1)    begin errors++; $display("FAIL unf_set got %b exp 1", bus.unf_err); end
        checks++; if (bus.pop_dvalid !== 1'b0) begin errors++; $display("FAIL unf_dvalid got %b exp 0", bus.pop_dvalid); end
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.unf_err !== 1'b0)    begin errors++; $display("FAIL unf_clear_prio got %b exp 0", bus.unf_err); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'((i + 1) * 8'h11), 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checks++; if (obs_push_ready !== 1'b1) begin errors++; $display("FAIL swap_push_ready got %b exp 1", obs_push_ready); end
        checks++; if (bus.pop_data !== 8'h44)  begin errors++; $display("FAIL swap_data got %h exp 44", bus.pop_data); end
        checks++; if (bus.pop_dvalid !== 1'b1) begin errors++; $display("FAIL swap_dvalid got %b exp 1", bus.pop_dvalid); end
        checks++; if (bus.count !== 3'd4)      begin errors++; $display("FAIL swap_count got %0d exp 4", bus.count); end
        checks++; if (bus.ovf_err !== 1'b0)    begin errors++; $display("FAIL swap_ovf got %b exp 0", bus.ovf_err); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.pop_data !== 8'h55)  begin errors++; $display("FAIL swap_next_pop got %h exp 55", bus.pop_data); end
        drive_cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checks++; if (obs_push_ready !== 1'b0) begin errors++; $display("FAIL ovf_push_ready got %b exp 0", obs_push_ready); end
        checks++; if (bus.ovf_err !== 1'b1)    begin errors++; $display("FAIL ovf_set got %b exp 1", bus.ovf_err); end
        checks++; if (bus.count !== 3'd4)      begin errors++; $display("FAIL ovf_count got %0d exp 4", bus.count); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.pop_data !== 8'h66)  begin errors++; $display("FAIL ovf_untouched got %h exp 66", bus.pop_data); end
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.ovf_err !== 1'b0)    begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.ovf_err); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd2)      begin errors++; $display("FAIL mid_pre_count got %0d exp 2", bus.count); end
        drive_cycle(1'b1, 8'hA3, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL mid_count got %0d exp 0", bus.count); end
        checks++; if (bus.empty !== 1'b1)      begin errors++; $display("FAIL mid_empty got %b exp 1", bus.empty); end
        checks++; if (bus.pop_dvalid !== 1'b0) begin errors++; $display("FAIL mid_dvalid got %b exp 0", bus.pop_dvalid); end
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.pop_dvalid !== 1'b0) begin errors++; $display("FAIL mid_dvalid_after got %b exp 0", bus.pop_dvalid); end
        checks++; if (bus.count !== 3'd0)      begin errors++; $display("FAIL mid_count_after got %0d exp 0", bus.count); end
    endtask

    task automatic test_random();
        logic pv, popv, clr, rs;
        for (int n = 0; n < 600; n++) begin
            pv   = ($urandom_range(0, 99) < 55);
            popv = ($urandom_range(0, 99) < 45);
            clr  = ($urandom_range(0, 99) < 5);
            rs   = ($urandom_range(0, 99) < 2);
            drive_cycle(pv, 8'($urandom), popv, clr, rs);
            checks++;
            if (obs_push_ready !== exp_push_ready || obs_pop_ready !== exp_pop_ready)
                begin errors++; $display("FAIL rnd_ready[%0d] got %b%b exp %b%b", n, obs_push_ready, obs_pop_ready, exp_push_ready, exp_pop_ready); end
            checks++;
            if (bus.count !== 3'(m_q.size()) || bus.full !== (m_q.size() == DEPTH) || bus.empty !== (m_q.size() == 0))
                begin errors++; $display("FAIL rnd_occupancy[%0d] got cnt=%0d f=%b e=%b exp cnt=%0d", n, bus.count, bus.full, bus.empty, m_q.size()); end
            checks++;
            if (bus.pop_dvalid !== m_dvalid || bus.pop_data !== m_pop_data)
                begin errors++; $display("FAIL rnd_pop[%0d] got v=%b d=%h exp v=%b d=%h", n, bus.pop_dvalid, bus.pop_data, m_dvalid, m_pop_data); end
            checks++;
            if (bus.ovf_err !== m_ovf || bus.unf_err !== m_unf)
                begin errors++; $display("FAIL rnd_errs[%0d] got %b%b exp %b%b", n, bus.ovf_err, bus.unf_err, m_ovf, m_unf); end
        end
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_valid  = 1'b0;
        bus.clr_err    = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
